// File: rtl/edge_stream_filter.sv
// Streaming 3x3 Sobel edge detector: grayscale conversion, two line buffers, a sliding
// window and a single registered output stage with valid/ready back-pressure.
module edge_stream_filter #(
   parameter int unsigned IMG_W    = 64,
   parameter int unsigned IMG_H    = 64,
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned CHANNELS = 3
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [1:0]                mode_i,
   input  logic [PIX_W-1:0]          thresh_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [CHANNELS*PIX_W-1:0] in_pixel_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [CHANNELS*PIX_W-1:0] out_pixel_o,
   output logic                      out_last_o
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned SW = PIX_W + 2;
   localparam int unsigned GW = PIX_W + 3;
   localparam int unsigned MW = PIX_W + 4;
   localparam logic [CW-1:0]    ColMax = CW'(IMG_W - 1);
   localparam logic [RW-1:0]    RowMax = RW'(IMG_H - 1);
   localparam logic [PIX_W-1:0] MaxPix = '1;

   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [1:0]         mode_q, mode_d;
   logic [PIX_W-1:0]   thresh_q, thresh_d;
   logic [PIX_W-1:0]   lb1_q [IMG_W];
   logic [PIX_W-1:0]   lb2_q [IMG_W];
   logic [PIX_W-1:0]   win_q [3][2];
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic [CHANNELS*PIX_W-1:0] out_pixel_q, out_pixel_d;

   logic               accept, produce, col_last, row_last;
   logic [PIX_W-1:0]   gray;
   logic [PIX_W-1:0]   p [3][3];
   logic signed [GW-1:0] s [3][3];
   logic signed [GW-1:0] gx, gy;
   logic [GW-1:0]      ax, ay;
   logic [MW-1:0]      mag;
   logic [PIX_W-1:0]   sat, res;

   if (CHANNELS == 3) begin : g_rgb
      logic [SW-1:0] sum;
      assign sum = SW'(in_pixel_i[PIX_W-1:0]) + {1'b0, in_pixel_i[2*PIX_W-1:PIX_W], 1'b0}
                 + SW'(in_pixel_i[3*PIX_W-1:2*PIX_W]);
      assign gray = PIX_W'(sum >> 2);
   end else begin : g_mono
      assign gray = in_pixel_i[PIX_W-1:0];
   end

   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   assign col_last   = (col_q == ColMax);
   assign row_last   = (row_q == RowMax);
   assign produce    = (row_q >= RW'(2)) && (col_q >= CW'(2));

   // Window = two registered columns plus the column arriving with this pixel.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         p[i][0] = win_q[i][0];
         p[i][1] = win_q[i][1];
      end
      p[0][2] = lb2_q[col_q];
      p[1][2] = lb1_q[col_q];
      p[2][2] = gray;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            s[i][j] = signed'(GW'(p[i][j]));
         end
      end
   end

   assign gx  = (s[0][2] + s[1][2] + s[1][2] + s[2][2]) - (s[0][0] + s[1][0] + s[1][0] + s[2][0]);
   assign gy  = (s[2][0] + s[2][1] + s[2][1] + s[2][2]) - (s[0][0] + s[0][1] + s[0][1] + s[0][2]);
   assign ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
   assign ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
   assign mag = MW'(ax) + MW'(ay);
   assign sat = (mag > MW'(MaxPix)) ? MaxPix : mag[PIX_W-1:0];

   always_comb begin
      res = sat;
      unique case (mode_q)
         2'd0:    res = p[1][1];
         2'd2:    res = (mag >= MW'(thresh_q)) ? MaxPix : '0;
         default: res = sat;
      endcase
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      mode_d      = mode_q;
      thresh_d    = thresh_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_pixel_d = out_pixel_q;
      if (accept) begin
         col_d = col_last ? '0 : col_q + CW'(1);
         if (col_last) begin
            row_d = row_last ? '0 : row_q + RW'(1);
         end
         if (col_q == '0 && row_q == '0) begin
            mode_d   = mode_i;
            thresh_d = thresh_i;
         end
         out_valid_d = produce;
         out_last_d  = produce && row_last && col_last;
         if (produce) begin
            out_pixel_d = {CHANNELS{res}};
         end
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= '0;
         thresh_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         mode_q      <= mode_d;
         thresh_q    <= thresh_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_pixel_q <= out_pixel_d;
      end
   end

   // Buffers and window are fully rewritten before any output depends on them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         lb2_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= gray;
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= p[i][1];
            win_q[i][1] <= p[i][2];
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_pixel_o = out_pixel_q;

endmodule

// File: tb/tb_edge_stream_filter.sv
// Randomized and directed bench for edge_stream_filter against a whole-frame reference model.
module tb_edge_stream_filter;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [1:0]  mode;
   logic [7:0]  thresh;
   logic [23:0] in_pixel, out_pixel;

   always #5 clk = ~clk;

   edge_stream_filter #(
      .IMG_W(W), .IMG_H(H), .PIX_W(8), .CHANNELS(3)
   ) dut (
      .clk_i(clk), .reset_i(reset), .mode_i(mode), .thresh_i(thresh),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pixel_i(in_pixel),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pixel_o(out_pixel),
      .out_last_o(out_last)
   );

   int          n_cmp, n_err;
   int          img [H][W];
   int          mr, mc, m_mode, m_thr, frame_outs;
   bit          m_valid, held;
   logic [24:0] held_val;
   logic [24:0] exp_q [$];
   logic [23:0] last_out;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int gray_of(input logic [23:0] px);
      return (int'(px[7:0]) + 2 * int'(px[15:8]) + int'(px[23:16])) / 4;
   endfunction

   function automatic logic [7:0] ref_out(input int r, input int c);
      int gx, gy, mag;
      gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
         - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
      if (m_mode == 0) return 8'(img[r-1][c-1]);
      if (m_mode == 2) return (mag >= m_thr) ? 8'hFF : 8'h00;
      return 8'(mag);
   endfunction

   function automatic logic [23:0] pix_of(input int kind, input int r, input int c);
      logic [7:0] v;
      case (kind)
         0:       v = 8'd100;
         1:       v = (c >= 2) ? 8'd255 : 8'd0;
         2:       v = 8'(16 * r + c);
         default: return 24'($urandom);
      endcase
      return {v, v, v};
   endfunction

   task automatic step(input bit iv, input logic [23:0] px, input bit ordy, output bit acc);
      logic [24:0] e;
      @(negedge clk);
      in_valid  = iv;
      in_pixel  = px;
      out_ready = ordy;
      #1;
      check_eq("in_ready", in_ready, !m_valid || ordy);
      check_eq("out_valid", out_valid, m_valid);
      if (held && out_valid) check_eq("hold_stable", {out_last, out_pixel}, held_val);
      held     = out_valid && !ordy;
      held_val = {out_last, out_pixel};
      if (out_valid && ordy) begin
         frame_outs++;
         last_out = out_pixel;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_output: got %0h expected none", out_pixel);
         end else begin
            e = exp_q.pop_front();
            check_eq("out_pixel", out_pixel, e[23:0]);
            check_eq("out_last", out_last, e[24]);
         end
      end
      acc = iv && in_ready;
      if (acc) begin
         if (mr == 0 && mc == 0) begin
            m_mode = int'(mode);
            m_thr  = int'(thresh);
         end
         img[mr][mc] = gray_of(px);
         if (mr >= 2 && mc >= 2) begin
            exp_q.push_back({(mr == H - 1 && mc == W - 1), {3{ref_out(mr, mc)}}});
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
         end
      end else if (ordy) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_last", out_last, 0);
      check_eq("rst_out_pixel", out_pixel, 0);
      check_eq("rst_in_ready", in_ready, 1);
      exp_q.delete();
      m_valid = 1'b0;
      held    = 1'b0;
      mr = 0; mc = 0; m_mode = 0; m_thr = 0;
   endtask

   task automatic send_frame(input int kind, input int md, input int thr, input int npix,
                             input bit rnd, input bit bp, input bit chg);
      int          idx, guard, bp_cnt;
      bit          iv, ordy, acc;
      logic [23:0] px;
      mode = 2'(md); thresh = 8'(thr);
      idx = 0; guard = 0; bp_cnt = 0; frame_outs = 0;
      px = pix_of(kind, 0, 0);
      while (idx < npix && guard < 2000) begin
         guard++;
         iv = rnd ? ($urandom_range(3) != 0) : 1'b1;
         if (bp && out_valid && bp_cnt < 5) begin
            ordy = 1'b0;
            bp_cnt++;
         end else begin
            ordy = rnd ? ($urandom_range(3) != 0) : 1'b1;
         end
         step(iv, px, ordy, acc);
         if (acc) begin
            idx++;
            px = pix_of(kind, idx / W, idx % W);
            if (chg && idx == 5) begin
               mode   = 2'($urandom);
               thresh = 8'($urandom);
            end
         end
      end
      if (npix == W * H) begin
         while (m_valid && guard < 2000) begin
            guard++;
            step(1'b0, 24'h0, 1'b1, acc);
         end
         check_eq("frame_outs", frame_outs, (W - 2) * (H - 2));
         check_eq("queue_empty", exp_q.size(), 0);
      end
      if (guard >= 2000) begin
         n_cmp++;
         n_err++;
         $display("FAIL frame_timeout: got %0d inputs expected %0d", idx, npix);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_pixel = '0;
      mode = 2'd0; thresh = 8'd0;
      repeat (2) @(negedge clk);
      do_reset();

      send_frame(0, 1, 0, W * H, 0, 0, 0);
      check_eq("uniform_mag", last_out, 24'h000000);
      send_frame(1, 1, 0, W * H, 0, 0, 0);
      check_eq("edge_mag_sat", last_out, 24'hFFFFFF);
      send_frame(2, 0, 0, W * H, 0, 0, 0);
      check_eq("ramp_pass", last_out, 24'h222222);
      send_frame(2, 3, 0, W * H, 0, 0, 0);
      check_eq("ramp_mag_mode3", last_out, 24'h888888);
      send_frame(1, 2, 200, W * H, 0, 0, 0);
      check_eq("edge_thresh", last_out, 24'hFFFFFF);
      send_frame(2, 2, 136, W * H, 0, 0, 0);
      check_eq("ramp_thresh_eq", last_out, 24'hFFFFFF);
      send_frame(2, 2, 137, W * H, 0, 0, 0);
      check_eq("ramp_thresh_above", last_out, 24'h000000);
      send_frame(1, 1, 0, W * H, 0, 1, 0);

      send_frame(3, 1, 0, 7, 0, 0, 0);
      do_reset();
      send_frame(1, 1, 0, W * H, 0, 0, 1);
      send_frame(3, 0, 0, 11, 1, 0, 0);
      do_reset();
      send_frame(2, 0, 0, W * H, 0, 0, 0);
      check_eq("post_reset_pass", last_out, 24'h222222);

      for (int f = 0; f < 25; f++) begin
         send_frame(3, int'($urandom_range(3)), int'($urandom_range(255)), W * H, 1,
                    ($urandom_range(3) == 0), ($urandom_range(1) == 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
